// File: rtl/ps2_key_pkg.sv
// Shared types and constants for the PS/2 key event decoder.
package ps2_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int unsigned EVT_EXT = 9;
  localparam int unsigned EVT_BRK = 8;
  localparam int unsigned EVT_W   = 10;

  function automatic logic [EVT_W-1:0] pack_evt(input logic ext, input logic brk,
                                               input logic [7:0] code);
    logic [EVT_W-1:0] evt;
    evt          = '0;
    evt[EVT_EXT] = ext;
    evt[EVT_BRK] = brk;
    evt[7:0]     = code;
    return evt;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO with sticky overflow; head reads as zero when empty.
module ps2_event_fifo
  import ps2_key_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = EVT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         clr_overflow,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         overflow,
  output logic         accepted
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW:0]   DEPTH_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q;
  logic          do_pop, drop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_CNT);
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_pop   = pop && !empty;
  assign accepted = push && (!full || do_pop);
  assign drop     = push && full && !do_pop;
  assign dout     = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow = overflow_q;

  always_comb begin
    count_d = count_q;
    case ({accepted, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (accepted) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accepted) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Folds E0/F0 prefixed PS/2 scan bytes into {ext, brk, code} events with an IRQ pulse.
// Optional PS2_TYPEMATIC_FILTER_EN suppresses repeated make events (auto-repeat).
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned PREFIX_TIMEOUT = 200000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_done_tick,
  input  logic [7:0]       key,
  input  logic             rd_en,
  output logic [EVT_W-1:0] evt_data,
  output logic             evt_valid,
  output logic             fifo_full,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic             key_irq
);

  localparam int unsigned CNT_W = $clog2(PREFIX_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PREFIX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             emit, emit_ext, emit_brk;
  logic             push, accepted, fifo_empty;
  logic             key_irq_q;
  logic [EVT_W-1:0] evt_in;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (rx_done_tick) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (key == PS2_EXT) begin
            state_d = ST_GOT_E0;
          end else if (key == PS2_BRK) begin
            state_d = ST_GOT_F0;
          end else begin
            emit = 1'b1;
          end
        end
        ST_GOT_E0: begin
          if (key == PS2_BRK) begin
            state_d = ST_GOT_E0F0;
          end else if (key != PS2_EXT) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_GOT_F0, ST_GOT_E0F0: begin
          // A prefix after F0 is a protocol error: restart as if seen from IDLE.
          if (key == PS2_EXT) begin
            state_d = ST_GOT_E0;
          end else if (key == PS2_BRK) begin
            state_d = ST_GOT_F0;
          end else begin
            emit     = 1'b1;
            emit_ext = (state_q == ST_GOT_E0F0);
            emit_brk = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == CNT_MAX) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] held_q;
  logic       held_vld_q;
  logic       suppress;

  assign suppress = emit && !emit_brk && held_vld_q && (held_q == {emit_ext, key});
  assign push     = emit && !suppress;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_q     <= '0;
      held_vld_q <= 1'b0;
    end else if (emit) begin
      if (emit_brk) begin
        held_vld_q <= 1'b0;
      end else begin
        held_q     <= {emit_ext, key};
        held_vld_q <= 1'b1;
      end
    end
  end
`else
  assign push = emit;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      key_irq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_irq_q <= accepted;
    end
  end

  assign evt_in = pack_evt(emit_ext, emit_brk, key);

  ps2_event_fifo #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push         (push),
    .din          (evt_in),
    .pop          (rd_en),
    .clr_overflow (clr_overflow),
    .dout         (evt_data),
    .empty        (fifo_empty),
    .full         (fifo_full),
    .overflow     (overflow),
    .accepted     (accepted)
  );

  assign evt_valid = !fifo_empty;
  assign key_irq   = key_irq_q;

endmodule
